// File: rtl/i2s_slave_tx.sv
// rtl/i2s_slave_tx.sv - I2S slave transmitter, BCLK/WS oversampled on WBs_CLK_i.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: repeat the last pair on underrun instead of sending silence.
module i2s_slave_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic                  I2S_S_EN_i,
    input  logic                  i2s_clk_i,
    input  logic                  i2s_ws_clk_i,
    input  logic [DATA_WIDTH-1:0] data_left_i,
    input  logic [DATA_WIDTH-1:0] data_right_i,
    input  logic                  load_i,
    output logic                  ready_o,
    output logic                  sample_req_o,
    output logic                  underrun_o,
    output logic                  i2s_dout_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   ws_r_q, ws_r_d;
    logic                   chan_start_q, chan_start_d;
    logic                   armed_q, armed_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]  hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0]  hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0]  act_l_q, act_l_d;
    logic [DATA_WIDTH-1:0]  act_r_q, act_r_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   dout_q, dout_d;
    logic                   sample_req_q, sample_req_d;
    logic                   underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]  word_sel;
    logic                   bclk_rise, bclk_fall;

    assign bclk_rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    assign bclk_fall = ~bclk_sync_q[SYNC_STAGES-1] & bclk_prev_q;

    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], i2s_clk_i};
        ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws_clk_i};
        bclk_prev_d  = bclk_sync_q[SYNC_STAGES-1];
        ws_r_d       = ws_r_q;
        chan_start_d = chan_start_q;
        armed_d      = armed_q;
        hold_full_d  = hold_full_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        sample_req_d = 1'b0;
        underrun_d   = 1'b0;
        word_sel     = '0;

        // Load decision is taken on the pre-load hold_full, so a same-cycle transfer wins.
        if (load_i && !hold_full_q) begin
            hold_l_d    = data_left_i;
            hold_r_d    = data_right_i;
            hold_full_d = 1'b1;
        end

        if (bclk_rise) begin
            ws_r_d       = ws_sync_q[SYNC_STAGES-1];
            chan_start_d = (ws_sync_q[SYNC_STAGES-1] != ws_r_q);
        end

        if (bclk_fall) begin
            chan_start_d = 1'b0;
            if (chan_start_q) begin
                if (!ws_r_q) begin
                    armed_d = 1'b1;
                    if (hold_full_q) begin
                        act_l_d      = hold_l_q;
                        act_r_d      = hold_r_q;
                        hold_full_d  = 1'b0;
                        sample_req_d = 1'b1;
                    end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                        act_l_d = act_l_q;
                        act_r_d = act_r_q;
`else
                        act_l_d = '0;
                        act_r_d = '0;
`endif
                        underrun_d = 1'b1;
                    end
                end
                if (armed_d) begin
                    word_sel  = ws_r_q ? act_r_d : act_l_d;
                    dout_d    = word_sel[DATA_WIDTH-1];
                    shift_d   = word_sel << 1;
                    bit_cnt_d = CW'(1);
                end else begin
                    dout_d = 1'b0;
                end
            end else if (armed_q && (bit_cnt_q < CW'(DATA_WIDTH))) begin
                dout_d    = shift_q[DATA_WIDTH-1];
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + CW'(1);
            end else begin
                dout_d = 1'b0;
            end
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            bclk_sync_q  <= '0;
            ws_sync_q    <= '0;
            bclk_prev_q  <= 1'b0;
            ws_r_q       <= 1'b0;
            chan_start_q <= 1'b0;
            armed_q      <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (!I2S_S_EN_i) begin
            bclk_sync_q  <= '0;
            ws_sync_q    <= '0;
            bclk_prev_q  <= 1'b0;
            ws_r_q       <= 1'b0;
            chan_start_q <= 1'b0;
            armed_q      <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            ws_sync_q    <= ws_sync_d;
            bclk_prev_q  <= bclk_prev_d;
            ws_r_q       <= ws_r_d;
            chan_start_q <= chan_start_d;
            armed_q      <= armed_d;
            hold_full_q  <= hold_full_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
        end
    end

    assign ready_o      = ~hold_full_q;
    assign sample_req_o = sample_req_q;
    assign underrun_o   = underrun_q;
    assign i2s_dout_o   = dout_q;

endmodule

// File: tb/tb_i2s_slave_tx.sv
// tb/tb_i2s_slave_tx.sv - directed self-checking bench for i2s_slave_tx.
module tb_i2s_slave_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        bclk = 1'b1;
    logic        ws = 1'b1;
    logic        load = 1'b0;
    logic [15:0] dl = 16'h0;
    logic [15:0] dr = 16'h0;
    logic        ready, sreq, urun, dout;

    int n_tests = 0;
    int n_fail = 0;
    logic got [0:8191];
    int gidx = 0;
    int sreq_total = 0;
    int urun_total = 0;

    i2s_slave_tx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .WBs_CLK_i   (clk),
        .WBs_RST_i   (rst),
        .I2S_S_EN_i  (en),
        .i2s_clk_i   (bclk),
        .i2s_ws_clk_i(ws),
        .data_left_i (dl),
        .data_right_i(dr),
        .load_i      (load),
        .ready_o     (ready),
        .sample_req_o(sreq),
        .underrun_o  (urun),
        .i2s_dout_o  (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sreq === 1'b1) sreq_total <= sreq_total + 1;
        if (urun === 1'b1) urun_total <= urun_total + 1;
    end

    // One BCLK period per bit: WS changes on the falling edge, dout captured at the rising edge.
    task automatic drive_bits(input int n, input logic w);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0;
            ws   = w;
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            got[gidx] = dout;
            gidx++;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] l, input logic [15:0] r);
        dl   = l;
        dr   = r;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_frame(input int n, output int sl, output int sr);
        sl = gidx;
        drive_bits(n, 1'b0);
        sr = gidx;
        drive_bits(n, 1'b1);
        drive_bits(1, 1'b1);
    endtask

    // The word sent in the slot starting at index s appears one BCLK later.
    function automatic logic [15:0] word_at(input int s);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = got[s+1+i];
        return w;
    endfunction

    function automatic logic any_one(input int s, input int n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < n; i++) r = r | got[s+i];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", dout); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_tests++; if (sreq !== 1'b0) begin n_fail++; $display("FAIL reset_sreq: got %b expected 0", sreq); end
        n_tests++; if (urun !== 1'b0) begin n_fail++; $display("FAIL reset_urun: got %b expected 0", urun); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int sl, sr, s0, sq0, ur0;
        sq0 = sreq_total; ur0 = urun_total;
        do_load(16'hA5C3, 16'h3C5A);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b expected 0", ready); end
        s0 = gidx;
        drive_bits(4, 1'b1);
        n_tests++; if (any_one(s0, 4) !== 1'b0) begin n_fail++; $display("FAIL single_preamble_quiet: got %b expected 0", any_one(s0, 4)); end
        run_frame(32, sl, sr);
        n_tests++; if (word_at(sl) !== 16'hA5C3) begin n_fail++; $display("FAIL single_left: got %h expected a5c3", word_at(sl)); end
        n_tests++; if (any_one(sl + 17, 16) !== 1'b0) begin n_fail++; $display("FAIL single_left_pad: got %b expected 0", any_one(sl + 17, 16)); end
        n_tests++; if (word_at(sr) !== 16'h3C5A) begin n_fail++; $display("FAIL single_right: got %h expected 3c5a", word_at(sr)); end
        n_tests++; if (any_one(sr + 17, 16) !== 1'b0) begin n_fail++; $display("FAIL single_right_pad: got %b expected 0", any_one(sr + 17, 16)); end
        n_tests++; if (sreq_total - sq0 !== 1) begin n_fail++; $display("FAIL single_sreq_count: got %0d expected 1", sreq_total - sq0); end
        n_tests++; if (urun_total - ur0 !== 0) begin n_fail++; $display("FAIL single_urun_count: got %0d expected 0", urun_total - ur0); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_empty: got %b expected 1", ready); end
    endtask

    task automatic test_underrun();
        int sl, sr, sq0, ur0;
        logic [15:0] exp_l, exp_r;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        exp_l = 16'hA5C3; exp_r = 16'h3C5A;
`else
        exp_l = 16'h0000; exp_r = 16'h0000;
`endif
        sq0 = sreq_total; ur0 = urun_total;
        run_frame(32, sl, sr);
        n_tests++; if (urun_total - ur0 !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d expected 1", urun_total - ur0); end
        n_tests++; if (sreq_total - sq0 !== 0) begin n_fail++; $display("FAIL underrun_sreq: got %0d expected 0", sreq_total - sq0); end
        n_tests++; if (word_at(sl) !== exp_l) begin n_fail++; $display("FAIL underrun_left: got %h expected %h", word_at(sl), exp_l); end
        n_tests++; if (word_at(sr) !== exp_r) begin n_fail++; $display("FAIL underrun_right: got %h expected %h", word_at(sr), exp_r); end
    endtask

    task automatic test_handshake();
        int sl, sr, sq0;
        sq0 = sreq_total;
        do_load(16'h1111, 16'h2222);
        do_load(16'h3333, 16'h4444);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready: got %b expected 0", ready); end
        run_frame(32, sl, sr);
        n_tests++; if (word_at(sl) !== 16'h1111) begin n_fail++; $display("FAIL hs_left: got %h expected 1111", word_at(sl)); end
        n_tests++; if (word_at(sr) !== 16'h2222) begin n_fail++; $display("FAIL hs_right: got %h expected 2222", word_at(sr)); end
        n_tests++; if (sreq_total - sq0 !== 1) begin n_fail++; $display("FAIL hs_sreq: got %0d expected 1", sreq_total - sq0); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_after: got %b expected 1", ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] wl [3];
        logic [15:0] wr [3];
        int sl [3];
        int sr [3];
        int sq0, ur0;
        wl[0] = 16'h1234; wr[0] = 16'h5678;
        wl[1] = 16'h9ABC; wr[1] = 16'hDEF0;
        wl[2] = 16'h0F0F; wr[2] = 16'hF0F0;
        sq0 = sreq_total; ur0 = urun_total;
        do_load(wl[0], wr[0]);
        for (int f = 0; f < 3; f++) begin
            sl[f] = gidx;
            drive_bits(16, 1'b0);
            if (f < 2) do_load(wl[f+1], wr[f+1]);
            sr[f] = gidx;
            drive_bits(16, 1'b1);
        end
        drive_bits(1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            n_tests++; if (word_at(sl[f]) !== wl[f]) begin n_fail++; $display("FAIL b2b_left%0d: got %h expected %h", f, word_at(sl[f]), wl[f]); end
            n_tests++; if (word_at(sr[f]) !== wr[f]) begin n_fail++; $display("FAIL b2b_right%0d: got %h expected %h", f, word_at(sr[f]), wr[f]); end
        end
        n_tests++; if (urun_total - ur0 !== 0) begin n_fail++; $display("FAIL b2b_urun: got %0d expected 0", urun_total - ur0); end
        n_tests++; if (sreq_total - sq0 !== 3) begin n_fail++; $display("FAIL b2b_sreq: got %0d expected 3", sreq_total - sq0); end
    endtask

    task automatic test_enable_drop();
        int sl, s2, sr, rl, rr, sq0, ur0;
        do_load(16'hFFFF, 16'hFFFF);
        sl = gidx;
        drive_bits(3, 1'b0);
        do_load(16'h1111, 16'h2222);
        drive_bits(3, 1'b0);
        n_tests++; if (dout !== 1'b1) begin n_fail++; $display("FAIL en_active_bit: got %b expected 1", dout); end
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL en_dout_clear: got %b expected 0", dout); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL en_hold_cleared: got %b expected 1", ready); end
        en = 1'b1;
        s2 = gidx;
        drive_bits(26, 1'b0);
        n_tests++; if (any_one(s2, 26) !== 1'b0) begin n_fail++; $display("FAIL en_left_rest_quiet: got %b expected 0", any_one(s2, 26)); end
        sr = gidx;
        drive_bits(32, 1'b1);
        n_tests++; if (any_one(sr, 32) !== 1'b0) begin n_fail++; $display("FAIL en_right_quiet: got %b expected 0", any_one(sr, 32)); end
        do_load(16'h8001, 16'h7FFE);
        sq0 = sreq_total; ur0 = urun_total;
        run_frame(32, rl, rr);
        n_tests++; if (word_at(rl) !== 16'h8001) begin n_fail++; $display("FAIL en_resume_left: got %h expected 8001", word_at(rl)); end
        n_tests++; if (word_at(rr) !== 16'h7FFE) begin n_fail++; $display("FAIL en_resume_right: got %h expected 7ffe", word_at(rr)); end
        n_tests++; if (sreq_total - sq0 !== 1) begin n_fail++; $display("FAIL en_resume_sreq: got %0d expected 1", sreq_total - sq0); end
        n_tests++; if (urun_total - ur0 !== 0) begin n_fail++; $display("FAIL en_resume_urun: got %0d expected 0", urun_total - ur0); end
    endtask

    task automatic test_reset_midrun();
        int s2, sr;
        do_load(16'hABCD, 16'h1234);
        drive_bits(8, 1'b0);
        n_tests++; if (dout !== 1'b1) begin n_fail++; $display("FAIL rstmid_active_bit: got %b expected 1", dout); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rstmid_dout: got %b expected 0", dout); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
        n_tests++; if ((sreq | urun) !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got %b expected 0", sreq | urun); end
        @(negedge clk);
        rst = 1'b0;
        s2 = gidx;
        drive_bits(24, 1'b0);
        sr = gidx;
        drive_bits(32, 1'b1);
        n_tests++; if (any_one(s2, 24) !== 1'b0) begin n_fail++; $display("FAIL rstmid_left_quiet: got %b expected 0", any_one(s2, 24)); end
        n_tests++; if (any_one(sr, 32) !== 1'b0) begin n_fail++; $display("FAIL rstmid_right_quiet: got %b expected 0", any_one(sr, 32)); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_handshake();
        test_back_to_back();
        test_enable_drop();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_slave_tx.md
Name: i2s_slave_tx

Overview:
- I2S slave transmitter: the transmit counterpart of the fabric I2S slave receiver.
- An external master drives bit clock i2s_clk_i and word select i2s_ws_clk_i; this block serialises 16-bit left/right samples onto i2s_dout_o.
- Runs entirely on fabric clock WBs_CLK_i. BCLK and WS are oversampled through synchronisers.
- Samples come from a Wishbone-side FIFO/DMA via a one-deep holding register with a load/ready handshake.

Parameters:
- DATA_WIDTH, 16: bits per channel word, MSB first.
- SYNC_STAGES, 2: synchroniser depth for i2s_clk_i and i2s_ws_clk_i (minimum 2).

Ports:
- WBs_CLK_i  input  1  fabric clock; the only clock; must be >= 8x BCLK frequency
- WBs_RST_i  input  1  reset, asynchronous, active-high
- I2S_S_EN_i  input  1  block enable; low = synchronous clear
- i2s_clk_i  input  1  external I2S bit clock (asynchronous, sampled)
- i2s_ws_clk_i  input  1  external word select; 0 = left, 1 = right (asynchronous, sampled)
- data_left_i  input  DATA_WIDTH  left sample to load
- data_right_i  input  DATA_WIDTH  right sample to load
- load_i  input  1  load strobe; accepted only when ready_o = 1
- ready_o  output  1  holding register empty
- sample_req_o  output  1  one-cycle pulse when the holding register moves to the active pair
- underrun_o  output  1  one-cycle pulse when a frame starts with the holding register empty
- i2s_dout_o  output  1  serial data output

Behaviour:
- Reset (WBs_RST_i, asynchronous) and I2S_S_EN_i = 0 (synchronous, every cycle low) clear all state:
  - outputs: i2s_dout_o = 0, ready_o = 1, sample_req_o = 0, underrun_o = 0
  - holding register empty; active pair = 0; armed = 0.
- Synchronisers: SYNC_STAGES flops on BCLK and on WS, plus one extra BCLK flop for edge detection.
  - rise = d_last & ~d_prev; fall = ~d_last & d_prev (one WBs cycle each).
  - Pin edge to internal pulse latency: SYNC_STAGES + 1 cycles.
- On rise: ws_r <= synced WS; ws_p <= ws_r. Set chan_start = (ws_r != ws_p) using the new values. chan_start holds until the next fall.
- On fall with chan_start = 1 and new channel = left (ws_r = 0):
  - Set armed = 1.
  - If holding register full: move it to the active pair, empty the holding register, pulse sample_req_o.
  - Otherwise: load the active pair with 0 (see Optional Feature) and pulse underrun_o.
- On fall with chan_start = 1 and armed = 1:
  - Load shifter from active_l (left) or active_r (right).
  - i2s_dout_o <= word[DATA_WIDTH-1]; bit_cnt <= 1.
  - MSB therefore appears on the BCLK falling edge after the WS transition (standard I2S one-bit delay).
- On fall without chan_start:
  - If bit_cnt < DATA_WIDTH: output the next bit and increment bit_cnt.
  - Otherwise: i2s_dout_o <= 0 with bit_cnt saturated. This zero-pads slots longer than DATA_WIDTH.
- Slots shorter than DATA_WIDTH: the word is truncated at the next WS edge; the LSBs are lost; no error flag.
- armed = 0: i2s_dout_o stays 0. A right channel seen before the first left edge is not transmitted.
- Handshake:
  - ready_o = ~hold_full.
  - load_i with ready_o = 1 captures both inputs and sets hold_full next cycle.
  - load_i with ready_o = 0 is ignored.
- Simultaneous load_i and left-channel start:
  - The transfer decision uses hold_full before the load.
  - If hold_full was 0: underrun; the loaded data lands in the holding register for the next frame.
  - If hold_full was 1: the transfer happens and the load is ignored, because ready_o was 0.
- i2s_dout_o is registered and changes only in the cycle after a fall pulse.

Optional Feature:
- Macro I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: on underrun, the active pair keeps its previous values, so the last frame repeats. underrun_o still pulses.
- Undefined: on underrun, the active pair is cleared to 0, so silence is sent.
- Reset and enable clear behave the same either way.

Test Plan:
- Reset: assert WBs_RST_i mid-run -> immediately i2s_dout_o = 0, ready_o = 1, no pulses; nothing transmitted until a ws 1->0 edge after release.
- Single frame, WBs = 16x BCLK, 64fs (32-bit slots): load L = 16'hA5C3, R = 16'h3C5A.
  - Expect i2s_dout_o sampled on BCLK rising edges: left = A5C3 MSB first starting one BCLK after the WS fall, then 16 zeros.
  - Right = 3C5A MSB first after the WS rise, then 16 zeros.
  - sample_req_o pulses once, ready_o returns to 1.
- Underrun: no load before the WS fall -> underrun_o pulses exactly once per frame; dout all zeros. With the macro defined, the previous A5C3/3C5A repeats.
- Handshake: load 16'h1111/16'h2222, then load 16'h3333/16'h4444 while ready_o = 0 -> second load ignored; next frame transmits 1111/2222.
- Short slots, 32fs (16-bit slots) back-to-back with a load every frame -> full words each frame; no underrun pulses.
- Enable drop mid-word: I2S_S_EN_i = 0 at bit 5 of the left word -> dout 0 next cycle, holding register emptied.
  - After re-enable, the first right slot stays 0; transmission resumes at the next left start.
